// File: rtl/array_queue_ctrl.sv
// FIFO controller that uses a single-port register array as queue storage and
// presents the queue head through a one-entry registered output slot.
module array_queue_ctrl #(
  parameter int width = 32,
  parameter int depth = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [width-1:0]             push_data,
  output logic                         pop_valid,
  input  logic                         pop_ready,
  output logic [width-1:0]             pop_data,
  output logic [$clog2(depth+2)-1:0]   count,
  output logic                         arr_write,
  output logic [7:0]                   arr_index,
  output logic [width-1:0]             arr_datain,
  input  logic [width-1:0]             arr_dataout
);

  localparam int aw   = $clog2(depth);
  localparam int cntw = $clog2(depth + 1);
  localparam int cw   = $clog2(depth + 2);

  localparam logic [1:0] mode_flush  = 2'd0;
  localparam logic [1:0] mode_read   = 2'd1;
  localparam logic [1:0] mode_bypass = 2'd2;
  localparam logic [1:0] mode_write  = 2'd3;

  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic [cntw-1:0]  arr_cnt;
  logic             out_valid;
  logic [width-1:0] out_data;
  logic             slot_free;
  logic [1:0]       mode;

  assign slot_free = !out_valid || pop_ready;

  // Refilling the slot from the array takes priority over accepting a push,
  // since the shared index allows only one array operation per cycle.
  always_comb begin
    mode       = mode_write;
    push_ready = 1'b0;
    arr_write  = 1'b0;
    if (flush)
      mode = mode_flush;
    else if (slot_free && arr_cnt != '0)
      mode = mode_read;
    else if (slot_free)
      mode = mode_bypass;

    case (mode)
      mode_bypass: push_ready = 1'b1;
      mode_write: begin
        push_ready = arr_cnt < cntw'(depth);
        arr_write  = push_valid && push_ready;
      end
      default: ;
    endcase
  end

  assign arr_index  = 8'(arr_write ? wr_ptr : rd_ptr);
  assign arr_datain = push_data;
  assign pop_valid  = out_valid;
  assign pop_data   = out_data;
  assign count      = cw'(arr_cnt) + cw'(out_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      arr_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (mode)
        mode_flush: begin
          wr_ptr    <= '0;
          rd_ptr    <= '0;
          arr_cnt   <= '0;
          out_valid <= 1'b0;
        end
        mode_read: begin
          out_data  <= arr_dataout;
          out_valid <= 1'b1;
          rd_ptr    <= rd_ptr + aw'(1);
          arr_cnt   <= arr_cnt - cntw'(1);
        end
        mode_bypass: begin
          if (push_valid) begin
            out_data  <= push_data;
            out_valid <= 1'b1;
          end else if (pop_ready && out_valid) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          if (arr_write) begin
            wr_ptr  <= wr_ptr + aw'(1);
            arr_cnt <= arr_cnt + cntw'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_array_queue_ctrl.sv
// Bench for array_queue_ctrl: an 8-entry array model, a per-cycle vector table,
// hand-written full/drain sequences and a random soak, all scoreboarded.
module tb_array_queue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] push_data = '0;
  logic        pop_valid;
  logic        pop_ready = 1'b0;
  logic [31:0] pop_data;
  logic [3:0]  count;
  logic        arr_write;
  logic [7:0]  arr_index;
  logic [31:0] arr_datain;
  logic [31:0] arr_dataout;

  logic [31:0] mem [8];
  logic [31:0] sbq [$];
  int total = 0;
  int bad = 0;

  typedef struct {
    logic        rst, flush, pv;
    logic [31:0] pd;
    logic        pr, chk;
    logic        e_pv;
    logic [31:0] e_pd;
    logic [3:0]  e_cnt;
    logic        e_prdy, e_aw;
    logic [7:0]  e_idx;
  } vec_t;

  vec_t vecs [$];

  always #5 clk = ~clk;

  array_queue_ctrl #(.width(32), .depth(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count), .arr_write(arr_write), .arr_index(arr_index),
    .arr_datain(arr_datain), .arr_dataout(arr_dataout)
  );

  // Single-port register array: write on the clock edge, combinational read.
  assign arr_dataout = mem[arr_index[2:0]];
  always @(posedge clk) if (arr_write) mem[arr_index[2:0]] <= arr_datain;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle's inputs after the falling edge, then updates the
  // scoreboard from the settled handshake before the next rising edge.
  task automatic applyStimulus(input logic r, input logic f, input logic pv,
                               input logic [31:0] pd, input logic pr);
    logic [31:0] head;
    @(negedge clk);
    rst = r; flush = f; push_valid = pv; push_data = pd; pop_ready = pr;
    #1;
    if (r || f) begin
      sbq.delete();
    end else begin
      checkOutput("sb_count", 32'(count), 32'(sbq.size()));
      checkOutput("sb_pop_valid", 32'(pop_valid), 32'(sbq.size() != 0));
      checkOutput("sb_arr_datain", arr_datain, push_data);
      if (pop_valid && pop_ready) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL sb_underflow: got pop of %0h expected no word", pop_data);
        end else begin
          head = sbq.pop_front();
          checkOutput("sb_pop_data", pop_data, head);
        end
      end
      if (pv && push_ready) sbq.push_back(pd);
    end
  endtask

  function automatic vec_t mk(logic r, logic f, logic pv, logic [31:0] pd, logic pr,
                              logic chk, logic epv, logic [31:0] epd, logic [3:0] ecnt,
                              logic eprdy, logic eaw, logic [7:0] eidx);
    vec_t v;
    v.rst = r; v.flush = f; v.pv = pv; v.pd = pd; v.pr = pr; v.chk = chk;
    v.e_pv = epv; v.e_pd = epd; v.e_cnt = ecnt; v.e_prdy = eprdy; v.e_aw = eaw; v.e_idx = eidx;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'hDEAD_0000 + 32'(i);

    // Reset, idle, bypass, pop-empty
    vecs.push_back(mk(1,0,0,0,0, 0, 0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0, 1, 0,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1, 0,0,0,1,0,0));
    vecs.push_back(mk(0,0,1,32'hA5A5_0001,0, 1, 0,0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1, 1,32'hA5A5_0001,1,1,0,0));
    vecs.push_back(mk(0,0,0,0,1, 1, 1,32'hA5A5_0001,1,1,0,0));
    // Fill to full: 0x10 to the slot, 0x11..0x18 to indices 0..7
    vecs.push_back(mk(0,0,1,32'h10,0, 1, 0,0,0,1,0,0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0,0,1,32'h10 + 32'(k),0, 1, 1,32'h10,4'(k),1,1,8'(k-1)));
    vecs.push_back(mk(0,0,1,32'h19,0, 1, 1,32'h10,9,0,0,0));
    // Drain, reading indices 0..7 with push stalled
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0,0,0,0,1, 1, 1,32'h10 + 32'(k),4'(9-k),0,0,8'(k)));
    vecs.push_back(mk(0,0,0,0,1, 1, 1,32'h18,1,1,0,0));
    // After wrap: 0x20 bypasses, 0x21 lands at index 0
    vecs.push_back(mk(0,0,1,32'h20,0, 1, 0,0,0,1,0,0));
    vecs.push_back(mk(0,0,1,32'h21,0, 1, 1,32'h20,1,1,1,0));
    vecs.push_back(mk(0,0,0,0,1, 1, 1,32'h20,2,0,0,0));
    vecs.push_back(mk(0,0,0,0,1, 1, 1,32'h21,1,1,0,1));
    // Steady-state push and pop every cycle
    vecs.push_back(mk(0,0,1,32'h40,1, 1, 0,0,0,1,0,1));
    vecs.push_back(mk(0,0,1,32'h41,1, 1, 1,32'h40,1,1,0,1));
    vecs.push_back(mk(0,0,1,32'h42,1, 1, 1,32'h41,1,1,0,1));
    vecs.push_back(mk(0,0,0,0,1, 1, 1,32'h42,1,1,0,1));
    vecs.push_back(mk(0,0,0,0,0, 1, 0,0,0,1,0,1));
    // Flush with count=5, then fresh data must not be stale
    vecs.push_back(mk(0,0,1,32'h50,0, 1, 0,0,0,1,0,1));
    for (int k = 1; k <= 4; k++)
      vecs.push_back(mk(0,0,1,32'h50 + 32'(k),0, 1, 1,32'h50,4'(k),1,1,8'(k)));
    vecs.push_back(mk(0,1,1,32'h55,1, 1, 1,32'h50,5,0,0,1));
    vecs.push_back(mk(0,0,0,0,0, 1, 0,0,0,1,0,0));
    vecs.push_back(mk(0,0,1,32'h33,0, 1, 0,0,0,1,0,0));
    vecs.push_back(mk(0,0,1,32'h34,0, 1, 1,32'h33,1,1,1,0));
    vecs.push_back(mk(0,0,0,0,1, 1, 1,32'h33,2,0,0,0));
    vecs.push_back(mk(0,0,0,0,1, 1, 1,32'h34,1,1,0,1));
    // Same with reset instead of flush
    vecs.push_back(mk(0,0,1,32'h60,0, 1, 0,0,0,1,0,1));
    for (int k = 1; k <= 4; k++)
      vecs.push_back(mk(0,0,1,32'h60 + 32'(k),0, 1, 1,32'h60,4'(k),1,1,8'(k)));
    vecs.push_back(mk(1,0,1,32'h65,1, 1, 1,32'h60,5,0,0,1));
    vecs.push_back(mk(0,0,0,0,0, 1, 0,0,0,1,0,0));
    vecs.push_back(mk(0,0,1,32'h77,0, 1, 0,0,0,1,0,0));
    vecs.push_back(mk(0,0,1,32'h78,0, 1, 1,32'h77,1,1,1,0));
    vecs.push_back(mk(0,0,0,0,1, 1, 1,32'h77,2,0,0,0));
    vecs.push_back(mk(0,0,0,0,1, 1, 1,32'h78,1,1,0,1));
    vecs.push_back(mk(0,0,0,0,0, 1, 0,0,0,1,0,1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].pv, vecs[i].pd, vecs[i].pr);
      if (vecs[i].chk) begin
        checkOutput($sformatf("r%0d_pop_valid", i), 32'(pop_valid), 32'(vecs[i].e_pv));
        if (vecs[i].e_pv)
          checkOutput($sformatf("r%0d_pop_data", i), pop_data, vecs[i].e_pd);
        checkOutput($sformatf("r%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
        checkOutput($sformatf("r%0d_push_ready", i), 32'(push_ready), 32'(vecs[i].e_prdy));
        checkOutput($sformatf("r%0d_arr_write", i), 32'(arr_write), 32'(vecs[i].e_aw));
        checkOutput($sformatf("r%0d_arr_index", i), 32'(arr_index), 32'(vecs[i].e_idx));
      end
    end

    // Full state: a pop frees room only on the following cycle
    for (int k = 0; k < 9; k++) applyStimulus(0, 0, 1, 32'h100 + 32'(k), 0);
    applyStimulus(0, 0, 1, 32'h1FF, 0);
    checkOutput("full_count", 32'(count), 32'd9);
    checkOutput("full_push_ready", 32'(push_ready), 32'd0);
    checkOutput("full_no_write", 32'(arr_write), 32'd0);
    applyStimulus(0, 0, 1, 32'h1FF, 1);
    checkOutput("fullpop_push_ready", 32'(push_ready), 32'd0);
    checkOutput("fullpop_no_write", 32'(arr_write), 32'd0);
    applyStimulus(0, 0, 1, 32'h1FF, 0);
    checkOutput("room_push_ready", 32'(push_ready), 32'd1);
    checkOutput("room_write", 32'(arr_write), 32'd1);
    checkOutput("room_index", 32'(arr_index), 32'd1);
    for (int k = 0; k < 12; k++) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("drained_count", 32'(count), 32'd0);

    // Random soak against the scoreboard
    for (int k = 0; k < 400; k++)
      applyStimulus(0, $urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)),
                    $urandom, $urandom_range(0, 2) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
